// File: rtl/data_mem_responder.sv
// Data-port responder: answers ReadData/WriteData from a word-addressed RAM, stalling via DataWaitreq for READ_WAIT/WRITE_WAIT cycles.
// Optional LED/switch MMIO regions are enabled by defining DMEM_MMIO_EN.
module data_mem_responder #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_BITS  = 12,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  input  logic [WORD_SIZE-1:0] SwIn,
  output logic [WORD_SIZE-1:0] LedOut
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int HI_W     = WORD_SIZE - ADDR_BITS;
  localparam logic [CNT_W-1:0] RD_N = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_N = CNT_W'(WRITE_WAIT);

  // The RAM read is registered, so a zero-wait read cannot return data.
  generate
    if (READ_WAIT < 1) begin : g_bad_read_wait
      $error("data_mem_responder: READ_WAIT must be at least 1");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   addr_q;
  logic                   wr_q;
  logic [WORD_SIZE-1:0]   ram_q;
  logic [WORD_SIZE-1:0]   mem [0:(1<<ADDR_BITS)-1];

  logic                   req;
  logic                   done;
  logic [WORD_SIZE-1:0]   eff_addr;
  logic                   eff_wr;
  logic [CNT_W-1:0]       n_wait;
  logic [HI_W-1:0]        hi;
  logic                   in_ram;
  logic                   ram_we;
  logic [WORD_SIZE-1:0]   rd_val;
  logic [WORD_SIZE-1:0]   led_q;

  assign req      = ReadData | WriteData;
  assign eff_addr = (state_q == S_WAIT) ? addr_q : DataAddr;
  assign eff_wr   = (state_q == S_WAIT) ? wr_q : WriteData;
  assign n_wait   = eff_wr ? WR_N : RD_N;
  assign hi       = eff_addr[WORD_SIZE-1:ADDR_BITS];
  assign in_ram   = (hi == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (n_wait == '0) begin
            done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        // Dropping req mid-transaction abandons it without committing.
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == n_wait) begin
          done    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign DataWaitreq = req & ~done;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        addr_q <= DataAddr;
        wr_q   <= WriteData;
      end
    end
  end

  assign ram_we = done & eff_wr & in_ram & ~Reset;

  always_ff @(posedge Clock) begin
    if (ram_we) begin
      mem[eff_addr[ADDR_BITS-1:0]] <= DataOut;
    end
    if (req) begin
      ram_q <= mem[eff_addr[ADDR_BITS-1:0]];
    end
  end

`ifdef DMEM_MMIO_EN
  logic is_led;
  logic is_sw;

  assign is_led = (hi == HI_W'(1));
  assign is_sw  = (hi == HI_W'(3));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      led_q <= '0;
    end else if (done & eff_wr & is_led) begin
      led_q <= DataOut;
    end
  end

  always_comb begin
    rd_val = '0;
    if (in_ram)      rd_val = ram_q;
    else if (is_led) rd_val = led_q;
    else if (is_sw)  rd_val = SwIn;
  end
`else
  logic unused_sw;

  assign unused_sw = ^SwIn;
  assign led_q     = '0;
  assign rd_val    = in_ram ? ram_q : '0;
`endif

  assign LedOut = led_q;
  assign DataIn = (done & ~eff_wr) ? rd_val : '0;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the processor's data port. It answers the processor's ReadData/WriteData requests from an on-chip word-addressed RAM. Completion is signalled by deasserting DataWaitreq after a parameterised number of wait states. It sits between the processor's memory stage and the data RAM and I/O, and is the stall source for that stage.

## Interface
Parameters:
- WORD_SIZE, 16, data and address width.
- ADDR_BITS, 12, RAM index width; depth = 2^ADDR_BITS words.
- READ_WAIT, 2, wait-state cycles per read; must be ≥1 because the RAM read is synchronous. Elaboration error if 0.
- WRITE_WAIT, 1, wait-state cycles per write; 0 is legal.

Ports:
- Clock  in  1  clock.
- Reset  in  1  reset; synchronous, active-high, clock Clock.
- DataAddr  in  WORD_SIZE  word address from the processor.
- DataOut  in  WORD_SIZE  processor write data.
- ReadData  in  1  read request.
- WriteData  in  1  write request.
- DataIn  out  WORD_SIZE  read data returned to the processor.
- DataWaitreq  out  1  high means "hold request, not done".
- SwIn  in  WORD_SIZE  switch input, used by MMIO only.
- LedOut  out  WORD_SIZE  LED register, used by MMIO only.

## Operation
- req = ReadData | WriteData. If both are high, the request is treated as a write and DataIn stays 0.
- FSM states: IDLE and WAIT.
- IDLE:
  - req=1 and N=0 (N = READ_WAIT or WRITE_WAIT): the request completes this cycle, DataWaitreq=0, and the FSM stays in IDLE.
  - req=1 and N>0: latch address and command, set cnt=1, DataWaitreq=1, go to WAIT.
- WAIT:
  - The latched address and command are used. Changes on the port during WAIT are ignored (protocol violation).
  - DataWaitreq = (cnt < N).
  - cnt increments each cycle while DataWaitreq=1.
  - The cycle with cnt==N is the completion cycle: DataWaitreq=0, then return to IDLE and clear cnt.
- Read: the RAM is read every request cycle at the effective address (port address in IDLE, latched address in WAIT). In the completion cycle, DataIn = registered RAM output. DataIn=0 in every other cycle.
- Write: mem[addr] <= DataOut at the posedge ending the completion cycle, using data sampled in that cycle.
- Address decode:
  - In range: addr[WORD_SIZE-1:ADDR_BITS]==0 → RAM.
  - Otherwise (without MMIO): a read returns 0 and a write is dropped. The handshake still completes with normal wait counts, so a bad address never hangs the pipeline.
- Back-to-back: if req is still high in the cycle after a completion, that cycle is k=0 of a new transaction.
- req dropped during WAIT (protocol violation): the FSM returns to IDLE and no write commits.

## Timing
- A request first seen in cycle k=0 has DataWaitreq=1 for k=0..N-1 and 0 at k=N. Latency is N+1 cycles.
- DataWaitreq is combinational from req and FSM state. It is 0 whenever req=0.
- Reset values: FSM=IDLE, cnt=0, DataIn=0, DataWaitreq=0 (with no req), LedOut=0. RAM contents are not cleared.
- Reset during WAIT aborts the transaction. Reset asserted on a completion-cycle posedge suppresses that write.
- Read during a write to the same address in an adjacent transaction returns the new data: the write commits before the next transaction's RAM read.

## Configuration
- DMEM_MMIO_EN defined:
  - Addresses with addr[WORD_SIZE-1:ADDR_BITS]==1 hit the LED register. A write sets LedOut; a read returns LedOut.
  - Addresses with addr[WORD_SIZE-1:ADDR_BITS]==3 hit the switches. A read returns SwIn, sampled in the completion cycle; a write is dropped.
  - MMIO uses the same wait counts as RAM.
- DMEM_MMIO_EN undefined: these regions behave as out-of-range, LedOut is tied to 0, and SwIn is ignored.

## Test plan
- Read latency: preload mem[0x005]=0xBEEF; hold ReadData=1, DataAddr=0x005 → DataWaitreq 1,1,0 and DataIn=0xBEEF only in the third cycle.
- Write then read: WriteData=1, addr 0x010, DataOut=0x1234 → Waitreq 1,0. Then an immediate read of 0x010 → 0x1234 on completion.
- Back-to-back reads: addrs 0x001 then 0x002 with req held continuously → two 3-cycle transactions, no idle gap, correct data for each.
- Out of range: read 0x2000 → completes in 3 cycles with DataIn=0. Write 0x2000 → no RAM word changes.
- MMIO (DMEM_MMIO_EN): write 0x1000 ← 0x00FF → LedOut=0x00FF after completion. Read 0x3000 with SwIn=0xA5A5 → DataIn=0xA5A5.
- Reset mid-write: Reset in cycle k=1 of a write to 0x020 (WRITE_WAIT=2) → mem[0x020] unchanged, DataWaitreq=0, FSM in IDLE next cycle.
